// File: rtl/uart_cmd_pkg.sv
// Shared command codes and FSM state encoding for the Hamming(7,4) UART command link.
package uart_cmd_pkg;

    localparam logic [3:0] CMD_TURN_ON  = 4'h6;
    localparam logic [3:0] CMD_TURN_OFF = 4'hD;
    localparam logic [3:0] CMD_TOGGLE   = 4'h9;
    localparam logic [3:0] CMD_ACK      = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SENDING,
        WAIT_ACK,
        RETRY
    } state_t;

endpackage

// File: rtl/uart_cmd_sender_if.sv
// Command-side and uart_tx/uart_rx-side signals of the command sender.
// master = the sender itself, slave = command logic plus the UART pair.
interface uart_cmd_sender_if;

    logic       cmd_valid;
    logic [3:0] cmd;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       done;
    logic       fail;
    logic [1:0] attempt;

    modport master (
        input  cmd_valid, cmd, tx_busy, rx_data, rx_done,
        output cmd_ready, tx_data, tx_start, done, fail, attempt
    );

    modport slave (
        output cmd_valid, cmd, tx_busy, rx_data, rx_done,
        input  cmd_ready, tx_data, tx_start, done, fail, attempt
    );

endinterface

// File: rtl/hamming_7_4_encoder.sv
// Combinational Hamming(7,4) encoder, mirror of hamming_7_4_decoder.
// Code word layout {d3,d2,d1,p3,d0,p2,p1}.
module hamming_7_4_encoder (
    input  logic [3:0] data_i,
    output logic [6:0] code_o
);

    logic p1, p2, p3;

    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3];
    assign p3 = data_i[1] ^ data_i[2] ^ data_i[3];

    assign code_o = {data_i[3], data_i[2], data_i[1], p3, data_i[0], p2, p1};

endmodule

// File: rtl/uart_cmd_sender.sv
// Sends a Hamming-encoded command through uart_tx, waits for the encoded ACK, retries on
// timeout or NACK. Optional macro HAMM_EXT_PARITY_EN adds an overall even parity bit in byte[7].
//
// state     | meaning
// IDLE      | ready for a command
// START     | one-cycle tx_start pulse to uart_tx
// WAIT_BUSY | waiting for uart_tx to take the byte
// SENDING   | uart_tx shifting the frame out
// WAIT_ACK  | waiting for the reply byte from uart_rx
// RETRY     | resend or give up
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1200,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_sender_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY);

    state_t           state_q;
    logic [3:0]       cmd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       attempt_q;
    logic             cmd_ready_q;
    logic             tx_start_q;
    logic             done_q;
    logic             fail_q;

    logic [6:0]       tx_code;
    logic [6:0]       ack_code;
    logic             tx_par;
    logic             ack_ok;

    hamming_7_4_encoder u_enc_tx  (.data_i(cmd_q),   .code_o(tx_code));
    hamming_7_4_encoder u_enc_ack (.data_i(CMD_ACK), .code_o(ack_code));

`ifdef HAMM_EXT_PARITY_EN
    assign tx_par = ^tx_code;
    assign ack_ok = (bus.rx_data[6:0] == ack_code) && (bus.rx_data[7] == ^bus.rx_data[6:0]);
`else
    logic unused_rx_msb;
    assign tx_par        = 1'b0;
    assign ack_ok        = (bus.rx_data[6:0] == ack_code);
    assign unused_rx_msb = bus.rx_data[7];
`endif

    // Saturating increment; the FSM leaves before CNT_LAST is passed, saturation is a backstop.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            attempt_q   <= '0;
            cmd_ready_q <= 1'b1;
            tx_start_q  <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q       <= bus.cmd;
                        attempt_q   <= '0;
                        cmd_ready_q <= 1'b0;
                        tx_start_q  <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= SENDING;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= RETRY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                SENDING: begin
                    if (!bus.tx_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A reply landing on the expiry cycle still counts.
                    if (bus.rx_done) begin
                        if (ack_ok) begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= RETRY;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= RETRY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RETRY: begin
                    if (attempt_q < RETRY_LAST) begin
                        attempt_q  <= attempt_q + 2'd1;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end else begin
                        fail_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx_data   = {tx_par, tx_code};
    assign bus.tx_start  = tx_start_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.attempt   = attempt_q;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Directed bench for uart_cmd_sender: bus-model stimulus, scoreboard queues for
// transmitted bytes and done/fail outcomes. Honours HAMM_EXT_PARITY_EN if defined.
module tb_uart_cmd_sender;
    import uart_cmd_pkg::*;

    localparam int T = 1200;

    typedef struct {
        logic       is_done;
        logic [1:0] attempt;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    logic [7:0] exp_tx[$];
    res_t       exp_res[$];
    res_t       mon_r;
    res_t       push_r;

    uart_cmd_sender_if bus ();

    uart_cmd_sender #(
        .ACK_TIMEOUT(T),
        .MAX_RETRY  (3),
        .CNT_W      (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_result(input logic is_done, input logic [1:0] att);
        res_t r;
        r.is_done = is_done;
        r.attempt = att;
        exp_res.push_back(r);
    endtask

    // Scoreboard: every tx_start and every done/fail pulse must match a queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.tx_start === 1'b1) begin
                checks++;
                assert (exp_tx.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_tx: observed tx_start with tx_data=%0h expected none", bus.tx_data);
                end
                if (exp_tx.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.done === 1'b1 || bus.fail === 1'b1) begin
                checks++;
                assert (exp_res.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result: observed done=%0b fail=%0b expected none", bus.done, bus.fail);
                end
                if (exp_res.size() != 0) begin
                    mon_r = exp_res.pop_front();
                    chk("result_kind", 32'({bus.done, bus.fail}), mon_r.is_done ? 32'd2 : 32'd1);
                    chk("result_attempt", 32'(bus.attempt), 32'(mon_r.attempt));
                end
            end
        end
    end

    task automatic wait_out(input int which, input int budget, output int cnt);
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < budget) begin
            @(negedge clk);
            cnt++;
            seen = (which == 0) ? bus.tx_start : (which == 1) ? bus.done : bus.fail;
        end
        checks++;
        assert (seen === 1'b1) else begin
            errors++;
            $error("FAIL wait_event_%0d: observed nothing after %0d cycles expected within %0d", which, cnt, budget);
        end
    endtask

    // Ends on the negedge where tx_start is visible.
    task automatic issue(input logic [3:0] c, input logic [7:0] exp_byte);
        @(negedge clk);
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        exp_tx.push_back(exp_byte);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("start_latency", 32'(bus.tx_start), 32'd1);
    endtask

    // Called on the tx_start negedge; ends on the negedge that drops tx_busy.
    task automatic frame(input int busy_cycles);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        chk("start_width", 32'(bus.tx_start), 32'd0);
        chk("ready_low_busy", 32'(bus.cmd_ready), 32'd0);
        repeat (busy_cycles - 1) @(negedge clk);
        bus.tx_busy = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 4'h0;
        bus.tx_busy   = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fail", 32'(bus.fail), 32'd0);
        chk("rst_attempt", 32'(bus.attempt), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // TURN_ON acknowledged first time
        push_result(1'b1, 2'd0);
        issue(CMD_TURN_ON, 8'h33);
        frame(20);
        repeat (3) @(negedge clk);
        reply(8'h00);
        chk("on_done", 32'(bus.done), 32'd1);
        chk("on_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        chk("on_done_width", 32'(bus.done), 32'd0);

        // TURN_OFF never answered: four transmissions then fail
        issue(CMD_TURN_OFF, 8'h66);
        for (int k = 0; k < 4; k++) begin
            frame(20);
            if (k < 3) begin
                exp_tx.push_back(8'h66);
                wait_out(0, T + 10, n);
                chk("ack_timeout_gap", 32'(n), 32'(T + 2));
            end else begin
                push_result(1'b0, 2'd3);
                wait_out(2, T + 10, n);
                chk("fail_gap", 32'(n), 32'(T + 2));
                chk("fail_attempt", 32'(bus.attempt), 32'd3);
                chk("fail_ready", 32'(bus.cmd_ready), 32'd1);
            end
        end
        repeat (3) @(negedge clk);

        // TOGGLE and the byte[7] handling of the reply
`ifdef HAMM_EXT_PARITY_EN
        issue(CMD_TOGGLE, 8'hCC);
        frame(20);
        repeat (2) @(negedge clk);
        exp_tx.push_back(8'hCC);
        reply(8'h80);
        wait_out(0, 10, n);
        push_result(1'b1, 2'd1);
        frame(20);
        repeat (2) @(negedge clk);
        reply(8'h00);
        chk("toggle_done", 32'(bus.done), 32'd1);
        chk("toggle_attempt", 32'(bus.attempt), 32'd1);
`else
        push_result(1'b1, 2'd0);
        issue(CMD_TOGGLE, 8'h4C);
        frame(20);
        repeat (2) @(negedge clk);
        reply(8'h80);
        chk("toggle_done", 32'(bus.done), 32'd1);
        chk("toggle_attempt", 32'(bus.attempt), 32'd0);
`endif
        repeat (3) @(negedge clk);

        // ACK arriving on the very cycle the counter expires
        push_result(1'b1, 2'd0);
        issue(CMD_TURN_ON, 8'h33);
        frame(20);
        repeat (T) @(negedge clk);
        reply(8'h00);
        chk("edge_ack_done", 32'(bus.done), 32'd1);
        chk("edge_ack_attempt", 32'(bus.attempt), 32'd0);

        // ACK strobes while idle are ignored
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reply(8'h00);
            chk("idle_rx_done", 32'(bus.done), 32'd0);
        end
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

        // uart_tx never goes busy; a second command mid-flight is dropped
        issue(CMD_TURN_ON, 8'h33);
        @(negedge clk);
        bus.cmd       = CMD_TURN_OFF;
        bus.cmd_valid = 1'b1;
        chk("busy_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        exp_tx.push_back(8'h33);
        wait_out(0, T + 10, n);
        chk("nobusy_gap0", 32'(n + 2), 32'(T + 2));
        for (int k = 0; k < 2; k++) begin
            exp_tx.push_back(8'h33);
            wait_out(0, T + 10, n);
            chk("nobusy_gap", 32'(n), 32'(T + 2));
        end
        push_result(1'b0, 2'd3);
        wait_out(2, T + 10, n);
        chk("nobusy_fail_gap", 32'(n), 32'(T + 2));
        repeat (5) @(negedge clk);
        chk("nobusy_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset while the second attempt is in SENDING
        issue(CMD_TURN_OFF, 8'h66);
        frame(20);
        exp_tx.push_back(8'h66);
        wait_out(0, T + 10, n);
        bus.tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_attempt", 32'(bus.attempt), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_fail", 32'(bus.fail), 32'd0);
        chk("mid_rst_attempt", 32'(bus.attempt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        bus.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        push_result(1'b1, 2'd0);
        issue(CMD_TURN_ON, 8'h33);
        frame(20);
        repeat (2) @(negedge clk);
        reply(8'h00);
        chk("post_rst_done", 32'(bus.done), 32'd1);
        chk("post_rst_attempt", 32'(bus.attempt), 32'd0);

        repeat (5) @(negedge clk);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        chk("res_queue_drained", 32'(exp_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sender.md
Name: uart_cmd_sender

Overview:
Command-initiator end of the Hamming(7,4)-over-UART link used by the LGBS module FPGAs. It accepts a 4-bit command and encodes it as a Hamming(7,4) byte. It drives an external uart_tx through a start/busy handshake, then waits for an encoded ACK from uart_rx. On timeout or a bad reply it retries; it reports done or fail once per command. It sits in the master/SPWM-generator FPGA top, between command logic and the uart_tx/uart_rx pair.

Parameters:
ACK_TIMEOUT, 1200, clk cycles to wait for tx_busy to rise and for the ACK byte (100 us at 12 MHz); minimum 2
MAX_RETRY, 3, retransmissions after the first attempt (0 = single attempt); range 0..3
CNT_W, 16, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  system clock (12 MHz from SB_HFOSC div 2)
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd  in  4  command nibble, sampled when cmd_valid && cmd_ready
cmd_ready  out  1  high only in IDLE
tx_data  out  8  encoded byte to uart_tx; held stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle start pulse to uart_tx
tx_busy  in  1  uart_tx busy
rx_data  in  8  byte from uart_rx
rx_done  in  1  one-cycle byte-received strobe
done  out  1  one-cycle pulse: command ACKed
fail  out  1  one-cycle pulse: retries exhausted
attempt  out  2  attempt index of the current or last command (0 = first)

Behaviour:
- Reset values (async, immediate): state IDLE, cmd_ready=1, tx_start=0, tx_data=0, done=0, fail=0, attempt=0, counter=0, latched cmd=0.
- Encoding: data d[3:0], p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3; byte[6:0]={d3,d2,d1,p3,d0,p2,p1}; byte[7]=0 unless the optional feature is enabled.
- ACK test: rx_data[6:0] == encode(4'h0) = 7'h00; byte[7] ignored.
- IDLE: on cmd_valid, latch cmd, load tx_data, attempt<=0 -> START.
- START: tx_start=1 for exactly this cycle, counter<=0 -> WAIT_BUSY.
- WAIT_BUSY: on tx_busy=1 -> SENDING. If counter reaches ACK_TIMEOUT-1 first, take the timeout path.
- SENDING: on tx_busy=0, counter<=0 -> WAIT_ACK.
- WAIT_ACK:
  - rx_done with an ACK byte -> done pulse next cycle -> IDLE.
  - rx_done with any other byte -> RETRY (NACK).
  - counter reaches ACK_TIMEOUT-1 -> RETRY.
  - If rx_done and timeout expiry fall in the same cycle, rx_done wins.
- RETRY: if attempt < MAX_RETRY, attempt<=attempt+1 -> START, resending the same tx_data. Otherwise fail pulse -> IDLE.
- Latency, IDLE to tx_start: 1 cycle after cmd_valid is accepted. done/fail are asserted in the cycle after the deciding event.
- rx_done outside WAIT_ACK is ignored. cmd_valid while not in IDLE is ignored and not queued.
- Counter saturates and never wraps; it resets on every entry to WAIT_BUSY and WAIT_ACK.
- Reset mid-operation: abort immediately with no done/fail pulse. An in-flight uart_tx frame is not recalled.

Optional Feature:
Macro HAMM_EXT_PARITY_EN.
- Defined: byte[7] = XOR of byte[6:0] (even overall parity, SECDED-style). The ACK test additionally requires rx_data[7] == ^rx_data[6:0]; a mismatch counts as NACK.
- Undefined: byte[7]=0 and rx_data[7] is ignored.

Decomposition:
- Package uart_cmd_pkg: command constants CMD_TURN_ON=4'h6, CMD_TURN_OFF=4'hD, CMD_TOGGLE=4'h9, CMD_ACK=4'h0; state encodings IDLE, START, WAIT_BUSY, SENDING, WAIT_ACK, RETRY.
- Sub-module hamming_7_4_encoder: combinational, 4-bit in, 7-bit out. Instantiated once for tx_data and once for the constant ACK comparison; it is the mirror of the existing hamming_7_4_decoder.

Test Plan:
- cmd=6: tx_data=0x33, tx_start high 1 cycle; model busy for 20 cycles, reply rx_data=0x00 -> done pulse, attempt=0.
- cmd=D: tx_data=0x66; no reply -> 4 transmissions, each ACK_TIMEOUT cycles after tx_busy falls, then fail pulse, attempt=3.
- cmd=9 with HAMM_EXT_PARITY_EN: tx_data=0xCC; reply 0x80 -> NACK, retry; reply 0x00 -> done, attempt=1. Without the macro: tx_data=0x4C, and reply 0x80 -> done.
- In WAIT_ACK, rx_done with 0x00 in the same cycle the counter expires -> done, no retry. rx_done=0x00 strobes in IDLE -> no done.
- tx_busy never rises -> timeout retries, then fail. cmd_valid pulsed while busy -> ignored, cmd_ready=0.
- Assert reset during SENDING -> all outputs take reset values in the same cycle; no done/fail. After release, the next cmd is sent normally.
